// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between decode (producer/consumer side) and the
// immediate generator. The generator itself uses the slave view.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) ();

  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       sel_i;
  logic [31:0]      instr_i;
  logic [TAG_W-1:0] tag_i;

  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  imm_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;

  // Generator side: takes instructions in, offers results out.
  modport slave (
    input  in_valid_i, sel_i, instr_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, tag_o, illegal_o
  );

  // Environment side: supplies instructions, consumes results.
  modport master (
    output in_valid_i, sel_i, instr_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, tag_o, illegal_o
  );

endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the immediate of a raw
// instruction word according to a format selector and queues the result,
// its sideband tag and an illegal-selector flag in a small FIFO so decode
// can keep running while the ALU is stalled.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  imm_gen_pipe_if.slave          bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [15:0]            err_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic             sign;
  logic [31:0]      imm32;
  logic             illegal;
  logic [XLEN-1:0]  immExt;
  logic             unusedInstrBits;

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      errCnt_q, errCnt_d;

  logic [XLEN-1:0]  immMem_q [DEPTH];
  logic [TAG_W-1:0] tagMem_q [DEPTH];
  logic [DEPTH-1:0] illMem_q;

  logic             push;
  logic             pop;

  assign sign = bus.instr_i[31];

  // The opcode field never contributes to an immediate.
  assign unusedInstrBits = ^bus.instr_i[6:0];

  // Assemble every format as a 32-bit value; zero-extended formats keep bit 31 clear.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (bus.sel_i)
      4'd0: imm32 = '0;
      4'd1, 4'd2, 4'd5:
        imm32 = {{20{sign}}, bus.instr_i[31:20]};
      4'd3:
        imm32 = {{20{sign}}, bus.instr_i[31:25], bus.instr_i[11:7]};
      4'd4:
        imm32 = {{19{sign}}, bus.instr_i[31], bus.instr_i[7],
                 bus.instr_i[30:25], bus.instr_i[11:8], 1'b0};
      4'd6:
        imm32 = {{11{sign}}, bus.instr_i[31], bus.instr_i[19:12],
                 bus.instr_i[20], bus.instr_i[30:21], 1'b0};
      4'd7:
        imm32 = {bus.instr_i[31:12], 12'b0};
      4'd8: begin
        if (XLEN == 64) imm32 = {26'b0, bus.instr_i[25:20]};
        else            imm32 = {27'b0, bus.instr_i[24:20]};
      end
      4'd9:
        imm32 = {27'b0, bus.instr_i[19:15]};
      default: begin
        imm32   = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Widen to XLEN; only the 64-bit build needs the upper sign fill.
  generate
    if (XLEN == 64) begin : gWide
      assign immExt = {{32{imm32[31]}}, imm32};
    end else begin : gNarrow
      assign immExt = imm32;
    end
  endgenerate

  // Ready depends only on registered occupancy and flush, never on the consumer.
  assign bus.in_ready_o  = (count_q < DEPTH_C) & ~flush_i;
  assign bus.out_valid_o = (count_q != '0);
  assign push            = bus.in_valid_i & bus.in_ready_o;
  assign pop             = bus.out_valid_o & bus.out_ready_i & ~flush_i;

  assign bus.imm_o     = immMem_q[rdPtr_q];
  assign bus.tag_o     = tagMem_q[rdPtr_q];
  assign bus.illegal_o = illMem_q[rdPtr_q];
  assign count_o       = count_q;
  assign err_cnt_o     = errCnt_q;

  // Next pointers, occupancy and error count; flush empties the queue but keeps the error count.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    errCnt_d = errCnt_q;
    if (flush_i) begin
      rdPtr_d = wrPtr_q;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
    if (push && illegal && (errCnt_q != 16'hFFFF)) errCnt_d = errCnt_q + 16'd1;
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      errCnt_q <= '0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      errCnt_q <= errCnt_d;
    end
  end

  // Result storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        immMem_q[i] <= '0;
        tagMem_q[i] <= '0;
      end
      illMem_q <= '0;
    end else if (push) begin
      immMem_q[wrPtr_q] <= immExt;
      tagMem_q[wrPtr_q] <= bus.tag_i;
      illMem_q[wrPtr_q] <= illegal;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit, 2-deep instance exercises
// decode, back-pressure, wrap, illegal selectors, flush and reset; a
// 64-bit instance checks the upper sign fill.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  logic flush32;
  logic flush64;
  logic [1:0]  count32;
  logic [1:0]  count64;
  logic [15:0] err32;
  logic [15:0] err64;

  int testCount = 0;
  int failCount = 0;

  // Directed decode vectors for the 32-bit instance with expected immediates.
  logic [3:0]  vSel   [7];
  logic [31:0] vInstr [7];
  logic [31:0] vExp   [7];

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(4)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush32),
    .bus       (bus32),
    .count_o   (count32),
    .err_cnt_o (err32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(4)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush64),
    .bus       (bus64),
    .count_o   (count64),
    .err_cnt_o (err64)
  );

  // Free-running 10 ns clock shared by both instances.
  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction request into the 32-bit instance.
  task automatic applyStimulus(input logic valid, input logic [3:0] sel,
                               input logic [31:0] instr, input logic [3:0] tag);
    bus32.in_valid_i = valid;
    bus32.sel_i      = sel;
    bus32.instr_i    = instr;
    bus32.tag_i      = tag;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, observed, expected);
    end
  endtask

  // Whole directed sequence, ending in the summary line.
  initial begin
    vSel[0] = 4'd7; vInstr[0] = 32'h123450B7; vExp[0] = 32'h12345000;
    vSel[1] = 4'd3; vInstr[1] = 32'hFE112C23; vExp[1] = 32'hFFFFFFF8;
    vSel[2] = 4'd5; vInstr[2] = 32'h80000067; vExp[2] = 32'hFFFFF800;
    vSel[3] = 4'd0; vInstr[3] = 32'hFFFFFFFF; vExp[3] = 32'h00000000;
    vSel[4] = 4'd8; vInstr[4] = 32'hFFF00013; vExp[4] = 32'h0000001F;
    vSel[5] = 4'd9; vInstr[5] = 32'hFFFFFFFF; vExp[5] = 32'h0000001F;
    vSel[6] = 4'd1; vInstr[6] = 32'h7FF00013; vExp[6] = 32'h000007FF;

    rst     = 1'b0;
    flush32 = 1'b0;
    flush64 = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
    bus32.out_ready_i = 1'b0;
    bus64.in_valid_i  = 1'b0;
    bus64.sel_i       = 4'd0;
    bus64.instr_i     = 32'd0;
    bus64.tag_i       = 4'd0;
    bus64.out_ready_i = 1'b1;
    tick();
    tick();

    // Reset state.
    checkOutput("rst_count",   count32,            64'd0);
    checkOutput("rst_valid",   bus32.out_valid_o,  64'd0);
    checkOutput("rst_imm",     bus32.imm_o,        64'd0);
    checkOutput("rst_tag",     bus32.tag_o,        64'd0);
    checkOutput("rst_illegal", bus32.illegal_o,    64'd0);
    checkOutput("rst_err",     err32,              64'd0);
    checkOutput("rst_ready",   bus32.in_ready_o,   64'd1);
    rst = 1'b1;
    tick();

    // Branch then JAL back-to-back with the consumer always ready.
    bus32.out_ready_i = 1'b1;
    applyStimulus(1'b1, 4'd4, 32'hFE000EE3, 4'd1);
    tick();
    checkOutput("br_valid", bus32.out_valid_o, 64'd1);
    checkOutput("br_imm",   bus32.imm_o,       64'hFFFFFFFC);
    checkOutput("br_tag",   bus32.tag_o,       64'd1);
    applyStimulus(1'b1, 4'd6, 32'h0080006F, 4'd2);
    tick();
    checkOutput("jal_imm",   bus32.imm_o, 64'h8);
    checkOutput("jal_tag",   bus32.tag_o, 64'd2);
    checkOutput("jal_count", count32,     64'd1);
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
    tick();
    checkOutput("drain_valid", bus32.out_valid_o, 64'd0);

    // Remaining formats streamed through, one result per cycle.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vSel[i], vInstr[i], 4'(i));
      tick();
      checkOutput($sformatf("fmt%0d_imm", i), bus32.imm_o,     {32'd0, vExp[i]});
      checkOutput($sformatf("fmt%0d_ill", i), bus32.illegal_o, 64'd0);
    end
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
    tick();

    // 64-bit instance: upper sign fill and the wider shift amount.
    bus64.in_valid_i = 1'b1; bus64.sel_i = 4'd7; bus64.instr_i = 32'hFFFFF037; bus64.tag_i = 4'd3;
    tick();
    checkOutput("x64_upper", bus64.imm_o, 64'hFFFFFFFFFFFFF000);
    checkOutput("x64_tag",   bus64.tag_o, 64'd3);
    bus64.sel_i = 4'd8; bus64.instr_i = 32'hFFF00013;
    tick();
    checkOutput("x64_shamt", bus64.imm_o, 64'h3F);
    bus64.sel_i = 4'd4; bus64.instr_i = 32'hFE000EE3;
    tick();
    checkOutput("x64_branch", bus64.imm_o, 64'hFFFFFFFFFFFFFFFC);
    bus64.in_valid_i = 1'b0;
    tick();

    // Back-pressure: fill, block the third push, then drain across the wrap.
    bus32.out_ready_i = 1'b0;
    applyStimulus(1'b1, 4'd1, 32'h00100093, 4'd3);
    tick();
    checkOutput("full_cnt1",   count32,          64'd1);
    checkOutput("full_rdy1",   bus32.in_ready_o, 64'd1);
    applyStimulus(1'b1, 4'd2, 32'hFFF00003, 4'd4);
    tick();
    checkOutput("full_cnt2",   count32,          64'd2);
    checkOutput("full_rdy2",   bus32.in_ready_o, 64'd0);
    applyStimulus(1'b1, 4'd1, 32'h7FF00013, 4'd5);
    tick();
    checkOutput("full_hold_cnt", count32,     64'd2);
    checkOutput("full_hold_imm", bus32.imm_o, 64'h1);
    checkOutput("full_hold_tag", bus32.tag_o, 64'd3);
    bus32.out_ready_i = 1'b1;
    tick();
    checkOutput("full_pop_cnt", count32,     64'd1);
    checkOutput("full_pop_imm", bus32.imm_o, 64'hFFFFFFFF);
    checkOutput("full_pop_tag", bus32.tag_o, 64'd4);
    tick();
    checkOutput("pp1_cnt", count32,     64'd1);
    checkOutput("pp1_imm", bus32.imm_o, 64'h7FF);
    checkOutput("pp1_tag", bus32.tag_o, 64'd5);
    applyStimulus(1'b1, 4'd3, 32'hFE112C23, 4'd6);
    tick();
    checkOutput("pp2_cnt", count32,     64'd1);
    checkOutput("pp2_imm", bus32.imm_o, 64'hFFFFFFF8);
    checkOutput("pp2_tag", bus32.tag_o, 64'd6);
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
    tick();
    checkOutput("pp_empty", count32, 64'd0);

    // Illegal selectors, then a flush that must not touch the error count.
    bus32.out_ready_i = 1'b0;
    applyStimulus(1'b1, 4'd12, 32'hFFFFFFFF, 4'd7);
    tick();
    applyStimulus(1'b1, 4'd12, 32'h12345678, 4'd8);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
    checkOutput("ill_cnt", count32,         64'd2);
    checkOutput("ill_imm", bus32.imm_o,     64'd0);
    checkOutput("ill_flg", bus32.illegal_o, 64'd1);
    checkOutput("ill_tag", bus32.tag_o,     64'd7);
    checkOutput("ill_err", err32,           64'd2);
    bus32.out_ready_i = 1'b1;
    tick();
    bus32.out_ready_i = 1'b0;
    checkOutput("ill2_tag", bus32.tag_o,     64'd8);
    checkOutput("ill2_flg", bus32.illegal_o, 64'd1);
    checkOutput("ill2_imm", bus32.imm_o,     64'd0);
    applyStimulus(1'b1, 4'd1, 32'h00500093, 4'd9);
    tick();
    checkOutput("pre_flush_cnt", count32, 64'd2);
    flush32 = 1'b1;
    bus32.out_ready_i = 1'b1;
    applyStimulus(1'b1, 4'd12, 32'd0, 4'd10);
    #1;
    checkOutput("flush_ready", bus32.in_ready_o, 64'd0);
    tick();
    flush32 = 1'b0;
    bus32.out_ready_i = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
    checkOutput("flush_cnt",   count32,           64'd0);
    checkOutput("flush_valid", bus32.out_valid_o, 64'd0);
    checkOutput("flush_err",   err32,             64'd2);
    applyStimulus(1'b1, 4'd1, 32'h00A00093, 4'd10);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
    checkOutput("post_flush_valid", bus32.out_valid_o, 64'd1);
    checkOutput("post_flush_imm",   bus32.imm_o,       64'hA);
    checkOutput("post_flush_tag",   bus32.tag_o,       64'd10);

    // Reset with two entries buffered drops everything, then restarts cleanly.
    applyStimulus(1'b1, 4'd1, 32'h00B00093, 4'd11);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
    checkOutput("pre_rst_cnt", count32, 64'd2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("mid_rst_valid", bus32.out_valid_o, 64'd0);
    checkOutput("mid_rst_cnt",   count32,           64'd0);
    checkOutput("mid_rst_err",   err32,             64'd0);
    checkOutput("mid_rst_imm",   bus32.imm_o,       64'd0);
    checkOutput("mid_rst_tag",   bus32.tag_o,       64'd0);
    applyStimulus(1'b1, 4'd7, 32'h123450B7, 4'd12);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'd0);
    checkOutput("post_rst_valid", bus32.out_valid_o, 64'd1);
    checkOutput("post_rst_imm",   bus32.imm_o,       64'h12345000);
    checkOutput("post_rst_tag",   bus32.tag_o,       64'd12);
    checkOutput("post_rst_cnt",   count32,           64'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
